counter_input_ctrl: RTL and testbench

- Front-end conditioner that sits directly upstream of the two-digit up/down counter on the board.
- Takes raw active-low push-buttons (run/pause, direction, load) and slide switches.
- Produces clean level controls `start`, `ud` and a held 7-bit `startValue` that feed the counter inputs of the same names.
- Provides metastability synchronisation, debounce, press-edge detection, toggle registers and clamped preset loading.

---
 rtl/counter_input_ctrl.sv | 65 ++++++
 tb/tb_counter_input_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_input_ctrl.sv
// counter_input_ctrl: syncs and debounces active-low keys key_start/key_dir/key_load plus sw (clk, active-low sync reset), driving start, ud, clamped startValue and one-cycle load_pulse
module counter_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W = 20,
  parameter int MAX_VAL = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start,
  input  logic       key_dir,
  input  logic       key_load,
  input  logic [6:0] sw,
  output logic       start,
  output logic       ud,
  output logic [6:0] startValue,
  output logic       load_pulse
);
  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] MAXV = 7'(MAX_VAL);
  logic [2:0] w_key;
  logic [6:0] w_clamp;
  logic [2:0] r_k1, r_k2, r_db, r_db_q, r_arm, r_press;
  logic [1:0] r_rdy;
  logic [6:0] r_sw1, r_sw2;
  logic [DB_W-1:0] r_cnt [3];
  assign w_key = {key_load, key_dir, key_start};
  assign w_clamp = r_sw2 > MAXV ? MAXV : r_sw2;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_k1 <= '1;
      r_k2 <= '1;
      r_db <= '1;
      r_db_q <= '1;
      r_arm <= '0;
      r_press <= '0;
      r_rdy <= '0;
      r_sw1 <= '0;
      r_sw2 <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      start <= 1'b0;
      ud <= 1'b0;
      startValue <= '0;
      load_pulse <= 1'b0;
    end else begin
      r_k1 <= w_key;
      r_k2 <= r_k1;
      r_sw1 <= sw;
      r_sw2 <= r_sw1;
      r_db_q <= r_db;
      r_rdy <= {r_rdy[0], 1'b1};
      r_arm <= r_arm | ({3{r_rdy[1]}} & r_k2 & r_db);
      r_press <= r_db_q & ~r_db & r_arm;
      for (int i = 0; i < 3; i++)
        if (r_k2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == LAST) begin
          r_db[i] <= r_k2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      load_pulse <= r_press[2];
      startValue <= r_press[2] ? w_clamp : startValue;
      start <= r_press[2] ? 1'b0 : start ^ r_press[0];
      ud <= ud ^ r_press[1];
    end
  end
endmodule

// File: tb/tb_counter_input_ctrl.sv
// tb_counter_input_ctrl: directed test-plan scenarios plus randomized keys checked against a window-based reference model
module tb_counter_input_ctrl;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_start = 1'b1;
  logic key_dir = 1'b1;
  logic key_load = 1'b1;
  logic [6:0] sw = '0;
  logic start, ud, load_pulse;
  logic [6:0] startValue;
  int errors = 0;
  int checks = 0;
  logic [D:0] m_hist [3];
  logic [2:0] m_db, m_arm, m_f1, m_f2;
  int m_since;
  logic [6:0] m_sw1, m_sw2, m_sv;
  logic m_start, m_ud, m_lp;

  counter_input_ctrl #(.DEBOUNCE_CYCLES(D), .DB_W(20), .MAX_VAL(99)) dut (
    .clk(clk), .reset(reset), .key_start(key_start), .key_dir(key_dir), .key_load(key_load),
    .sw(sw), .start(start), .ud(ud), .startValue(startValue), .load_pulse(load_pulse)
  );

  always #5 clk = ~clk;

  // A key level is accepted once the last D synchronised samples all disagree with
  // the stable level; the resulting action lands two edges after acceptance.
  // Keys seen held through reset are ignored until they are observed released.
  task automatic model_step();
    logic [2:0] raw, fell;
    raw = {key_load, key_dir, key_start};
    if (!reset) begin
      for (int k = 0; k < 3; k++) m_hist[k] = '1;
      m_db = '1; m_arm = '0; m_f1 = '0; m_f2 = '0; m_since = 0;
      m_sw1 = '0; m_sw2 = '0; m_sv = '0; m_start = 1'b0; m_ud = 1'b0; m_lp = 1'b0;
    end else begin
      m_lp = m_f2[2];
      if (m_f2[2]) begin
        m_sv = (m_sw2 > 7'd99) ? 7'd99 : m_sw2;
        m_start = 1'b0;
      end else if (m_f2[0]) m_start = !m_start;
      if (m_f2[1]) m_ud = !m_ud;
      m_f2 = m_f1;
      for (int k = 0; k < 3; k++) begin
        fell[k] = m_db[k] && (m_hist[k][D:1] == '0);
        m_f1[k] = fell[k] && m_arm[k];
        if (m_since >= 2 && m_hist[k][1] && m_db[k]) m_arm[k] = 1'b1;
        if (fell[k] || (!m_db[k] && (&m_hist[k][D:1]))) m_db[k] = !m_db[k];
        m_hist[k] = {m_hist[k][D-1:0], raw[k]};
      end
      if (m_since < 3) m_since++;
      m_sw2 = m_sw1;
      m_sw1 = sw;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic keys(input logic [2:0] v);
    {key_load, key_dir, key_start} = v;
  endtask

  // m bit0 = start, bit1 = dir, bit2 = load
  task automatic press(input logic [2:0] m, input int n_low, input int n_high);
    keys(~m);
    tick(n_low);
    keys(3'b111);
    tick(n_high);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    keys(3'b111);
    sw = 7'd55;
    tick(2);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    checks++; if (ud !== 1'b0) begin errors++; $display("FAIL reset_ud: got %b want 0", ud); end
    checks++; if (startValue !== 7'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", startValue); end
    checks++; if (load_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", load_pulse); end
    reset = 1'b1;
    tick(3);
    checks++; if ({start, ud, load_pulse} !== 3'b000 || startValue !== 7'd0) begin
      errors++; $display("FAIL reset_idle: got start=%b ud=%b lp=%b sv=%0d want all 0", start, ud, load_pulse, startValue);
    end
  endtask

  task automatic test_latency();
    keys(3'b110);
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (start !== (e >= 8)) begin errors++; $display("FAIL latency_e%0d: got start=%b want %b", e, start, e >= 8); end
    end
    keys(3'b111);
    tick(10);
    checks++; if (start !== 1'b1 || ud !== 1'b0 || startValue !== 7'd0) begin
      errors++; $display("FAIL latency_hold: got start=%b ud=%b sv=%0d want 1 0 0", start, ud, startValue);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 28; i++) begin
      keys((i < 20 && i % 4 < 3) ? 3'b110 : 3'b111);
      tick();
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL bounce_t%0d: got start=%b want 1", i, start); end
    end
    press(3'b001, 10, 10);
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL bounce_clean: got start=%b want 0", start); end
  endtask

  task automatic test_dir();
    press(3'b001, 10, 10);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL dir_prestart: got start=%b want 1", start); end
    keys(3'b101);
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++; if (ud !== (i >= 7)) begin errors++; $display("FAIL dir_hold_t%0d: got ud=%b want %b", i, ud, i >= 7); end
    end
    keys(3'b111);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (ud !== 1'b1) begin errors++; $display("FAIL dir_release_t%0d: got ud=%b want 1", i, ud); end
    end
    press(3'b010, 10, 10);
    checks++; if (ud !== 1'b0 || start !== 1'b1) begin
      errors++; $display("FAIL dir_second: got ud=%b start=%b want 0 1", ud, start);
    end
  endtask

  task automatic test_load();
    int vals [2] = '{45, 120};
    int exps [2] = '{45, 99};
    int pulses;
    for (int v = 0; v < 2; v++) begin
      sw = 7'(vals[v]);
      tick(3);
      pulses = 0;
      keys(3'b011);
      for (int i = 0; i < 20; i++) begin
        if (i == 10) keys(3'b111);
        tick();
        if (load_pulse === 1'b1) begin
          pulses++;
          checks++; if (startValue !== 7'(exps[v]) || start !== 1'b0 || i != 7) begin
            errors++; $display("FAIL load_pulse_v%0d: got sv=%0d start=%b at t%0d want sv=%0d start=0 at t7", vals[v], startValue, start, i, exps[v]);
          end
        end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL load_count_v%0d: got %0d pulses want 1", vals[v], pulses); end
      checks++; if (startValue !== 7'(exps[v])) begin errors++; $display("FAIL load_value_v%0d: got %0d want %0d", vals[v], startValue, exps[v]); end
    end
    sw = 7'd10;
    tick(12);
    checks++; if (startValue !== 7'd99) begin errors++; $display("FAIL load_hold: got %0d want 99", startValue); end
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    sw = 7'd77;
    tick(3);
    keys(3'b010);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) keys(3'b111);
      tick();
      if (load_pulse === 1'b1) pulses++;
    end
    checks++; if (start !== 1'b0 || startValue !== 7'd77 || pulses !== 1) begin
      errors++; $display("FAIL sim_load_start: got start=%b sv=%0d pulses=%0d want 0 77 1", start, startValue, pulses);
    end
    press(3'b011, 10, 10);
    checks++; if (start !== 1'b1 || ud !== 1'b1) begin
      errors++; $display("FAIL sim_start_dir: got start=%b ud=%b want 1 1", start, ud);
    end
  endtask

  task automatic test_reset_mid();
    sw = 7'd30;
    tick(3);
    press(3'b100, 10, 10);
    press(3'b001, 10, 10);
    checks++; if (start !== 1'b1 || ud !== 1'b1 || startValue !== 7'd30) begin
      errors++; $display("FAIL rmid_pre: got start=%b ud=%b sv=%0d want 1 1 30", start, ud, startValue);
    end
    keys(3'b110);
    tick(3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if ({start, ud, load_pulse} !== 3'b000 || startValue !== 7'd0) begin
      errors++; $display("FAIL rmid_reset: got start=%b ud=%b lp=%b sv=%0d want all 0", start, ud, load_pulse, startValue);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL rmid_held_t%0d: got start=%b want 0", i, start); end
    end
    keys(3'b111);
    tick(10);
    press(3'b001, 10, 10);
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL rmid_fresh: got start=%b want 1", start); end
  endtask

  task automatic test_random();
    logic [2:0] k = 3'b111;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) k[b] = ~k[b];
      keys(k);
      if ($urandom_range(0, 7) == 0) sw = 7'($urandom_range(0, 127));
      reset = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (start !== m_start || ud !== m_ud || startValue !== m_sv || load_pulse !== m_lp) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_t%0d: got start=%b ud=%b sv=%0d lp=%b want %b %b %0d %b",
                   i, start, ud, startValue, load_pulse, m_start, m_ud, m_sv, m_lp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_dir();
    test_load();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
